rst_seq: RTL and testbench

Parametrised multi-channel reset/enable sequencer. It takes the synchronous system reset plus a software reset request, and releases NCH downstream reset domains one after another at fixed spacing. Each domain gets a delayed enable, so datapaths start only after their registers are out of reset. It sits directly behind the top-level reset synchroniser and drives the per-block resets and enables of the core.

---
 rtl/rst_seq.sv | 205 ++++++++++++++++++++
 tb/tb_rst_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: staggered release of NCH reset domains with per-channel delayed enables; all outputs registered.
// A filtered sreq restarts the sequence; define RST_SEQ_REVERSE_EN to drain channels high-to-low instead of clearing at once.
module rst_seq #(
  parameter int NCH   = 4,
  parameter int HOLD  = 8,
  parameter int STAGE = 4,
  parameter int ENAD  = 2,
  parameter int FILT  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sreq,
  output logic [NCH-1:0] rst_n,
  output logic [NCH-1:0] ena,
  output logic           busy,
  output logic           done
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int SW = $clog2(STAGE + 1);
  localparam int CW = $clog2(NCH + 1);
  localparam int FW = $clog2(FILT + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(NCH - 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(FILT);

`ifdef RST_SEQ_REVERSE_EN
  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;
`endif

  state_t                     state_q, state_d;
  logic [HW-1:0]              hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]              stg_cnt_q, stg_cnt_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic [FW-1:0]              filt_cnt_q, filt_cnt_d;
  logic [NCH-1:0]             rst_n_q, rst_n_d;
  logic [NCH-1:0][ENAD-1:0]   sh_q, sh_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic                       req_act;
  logic                       req_fire;

  // Saturating request filter: active from the edge it reaches FILT until sreq drops.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (!sreq) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q != FILT_MAX) begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  assign req_act  = (filt_cnt_d == FILT_MAX);
  assign req_fire = req_act && (filt_cnt_q != FILT_MAX);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    ch_d       = ch_q;
    rst_n_d    = rst_n_q;

    case (state_q)
      S_HOLD: begin
        if (req_act) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          stg_cnt_d  = '0;
          ch_d       = CW'(1);
          rst_n_d[0] = 1'b1;
          state_d    = (NCH == 1) ? S_RUN : S_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      S_RELEASE: begin
        if (stg_cnt_q == STAGE_LAST) begin
          stg_cnt_d = '0;
          for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == ch_q) rst_n_d[i] = 1'b1;
          end
          ch_d = ch_q + CW'(1);
          if (ch_q == CH_LAST) state_d = S_RUN;
        end else begin
          stg_cnt_d = stg_cnt_q + SW'(1);
        end
      end

      S_RUN: begin
        state_d = S_RUN;
      end

`ifdef RST_SEQ_REVERSE_EN
      S_DRAIN: begin
        if (stg_cnt_q == STAGE_LAST) begin
          stg_cnt_d = '0;
          for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == ch_q) rst_n_d[i] = 1'b0;
          end
          if (ch_q == '0) begin
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end else begin
            ch_d = ch_q - CW'(1);
          end
        end else begin
          stg_cnt_d = stg_cnt_q + SW'(1);
        end
      end
`endif

      default: begin
        state_d = S_HOLD;
      end
    endcase

`ifdef RST_SEQ_REVERSE_EN
    // A release scheduled for the firing edge is cancelled; the top channel goes down first.
    if (req_fire && (state_q != S_DRAIN)) begin
      rst_n_d          = rst_n_q;
      rst_n_d[NCH-1]   = 1'b0;
      stg_cnt_d        = '0;
      hold_cnt_d       = '0;
      if (NCH == 1) begin
        state_d = S_HOLD;
      end else begin
        ch_d    = CW'(NCH - 2);
        state_d = S_DRAIN;
      end
    end
`else
    if (req_fire) begin
      rst_n_d    = '0;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      state_d    = S_HOLD;
    end
`endif
  end

  // Enable delay lines follow rst_n but clear on the same edge rst_n falls.
  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n_d[i]) begin
        sh_d[i] = '0;
      end else begin
        sh_d[i] = ENAD'({sh_q[i], rst_n_q[i]});
      end
    end
    done_d = (state_d == S_RUN) && sh_d[NCH-1][ENAD-1];
    busy_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      ch_q       <= '0;
      filt_cnt_q <= '0;
      rst_n_q    <= '0;
      sh_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      ch_q       <= ch_d;
      filt_cnt_q <= filt_cnt_d;
      rst_n_q    <= rst_n_d;
      sh_q       <= sh_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    ena = '0;
    for (int i = 0; i < NCH; i++) begin
      ena[i] = sh_q[i][ENAD-1];
    end
  end

  assign rst_n = rst_n_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default-parameter instance plus an NCH=1/HOLD=1/ENAD=1 instance.
module tb_rst_seq;

  logic       clk;
  logic       rst;
  logic       sreq;
  logic [3:0] rst_n;
  logic [3:0] ena;
  logic       busy;
  logic       done;

  logic       sreq1;
  logic [0:0] rst_n1;
  logic [0:0] ena1;
  logic       busy1;
  logic       done1;

  int n_chk;
  int n_bad;
  int cur_edge;

  rst_seq u_dut (
    .clk   (clk),
    .rst   (rst),
    .sreq  (sreq),
    .rst_n (rst_n),
    .ena   (ena),
    .busy  (busy),
    .done  (done)
  );

  rst_seq #(.NCH(1), .HOLD(1), .STAGE(4), .ENAD(1), .FILT(3)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .sreq  (sreq1),
    .rst_n (rst_n1),
    .ena   (ena1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cur_edge, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk edges 1..n of a fresh release, checking against the closed-form edge numbers.
  task automatic seq_check(input string tag, input int n, input bit with1);
    logic [3:0] xr;
    logic [3:0] xe;
    for (int e = 1; e <= n; e++) begin
      if (e > 1) sreq = 1'b0;
      step();
      cur_edge = e;
      for (int i = 0; i < 4; i++) begin
        xr[i] = (e >= 8 + 4 * i);
        xe[i] = (e >= 10 + 4 * i);
      end
      chk({tag, "_rst_n"}, 32'(rst_n), 32'(xr));
      chk({tag, "_ena"},   32'(ena),   32'(xe));
      chk({tag, "_done"},  32'(done),  32'(e >= 22));
      chk({tag, "_busy"},  32'(busy),  32'(e < 22));
      if (with1) begin
        chk({tag, "_n1_rst_n"}, 32'(rst_n1), 32'(e >= 1));
        chk({tag, "_n1_ena"},   32'(ena1),   32'(e >= 2));
        chk({tag, "_n1_done"},  32'(done1),  32'(e >= 2));
        chk({tag, "_n1_busy"},  32'(busy1),  32'(e < 2));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_n"}, 32'(rst_n), 32'h0);
    chk({tag, "_ena"},   32'(ena),   32'h0);
    chk({tag, "_busy"},  32'(busy),  32'h1);
    chk({tag, "_done"},  32'(done),  32'h0);
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_rst_n"}, 32'(rst_n), 32'hF);
    chk({tag, "_ena"},   32'(ena),   32'hF);
    chk({tag, "_done"},  32'(done),  32'h1);
    chk({tag, "_busy"},  32'(busy),  32'h0);
  endtask

  initial begin
    n_chk    = 0;
    n_bad    = 0;
    cur_edge = 0;
    rst      = 1'b1;
    sreq     = 1'b0;
    sreq1    = 1'b0;

    // Reset state on both instances
    repeat (3) step();
    chk_reset_vals("reset");
    chk("reset_n1_rst_n", 32'(rst_n1), 32'h0);
    chk("reset_n1_ena",   32'(ena1),   32'h0);
    chk("reset_n1_busy",  32'(busy1),  32'h1);
    chk("reset_n1_done",  32'(done1),  32'h0);

    // Power-on release sequence
    rst = 1'b0;
    seq_check("boot", 22, 1'b1);
    repeat (3) begin
      step();
      chk_run("run_hold");
    end

    // Short sreq pulse (FILT-1 edges) is ignored
    sreq = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      step();
      cur_edge = j;
      chk_run("short_req");
    end
    sreq = 1'b0;
    repeat (3) begin
      step();
      chk_run("short_after");
    end

    // Request held past FILT: fires on the third high edge
    sreq = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      step();
      cur_edge = j;
      chk_run("req_pre");
    end
    step();
    cur_edge = 3;
`ifdef RST_SEQ_REVERSE_EN
    chk("drain_k_rst_n", 32'(rst_n), 32'h7);
    chk("drain_k_ena",   32'(ena),   32'h7);
    chk("drain_k_done",  32'(done),  32'h0);
    chk("drain_k_busy",  32'(busy),  32'h1);
    // Channel 3-j clears at k + 4j; sreq drops two edges after firing
    for (int j = 1; j <= 12; j++) begin
      sreq = (j <= 2);
      step();
      cur_edge = j;
      chk("drain_rst_n", 32'(rst_n), 32'(4'hF >> (1 + j / 4)));
      chk("drain_ena",   32'(ena),   32'(4'hF >> (1 + j / 4)));
      chk("drain_done",  32'(done),  32'h0);
    end
    sreq = 1'b0;
    seq_check("redrain", 22, 1'b0);
`else
    chk_reset_vals("req_fire");
    // Stays cleared while sreq remains high
    for (int j = 1; j <= 2; j++) begin
      step();
      cur_edge = 3 + j;
      chk_reset_vals("req_held");
    end
    sreq = 1'b0;
    seq_check("rerel", 22, 1'b0);
`endif

    // rst pulsed on edge 14 of a release
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    seq_check("mid_pre", 13, 1'b0);
    rst = 1'b1;
    step();
    cur_edge = 14;
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    seq_check("mid_restart", 22, 1'b0);

    // rst and sreq together: rst wins and the filter count is discarded
    rst  = 1'b1;
    sreq = 1'b1;
    repeat (3) step();
    cur_edge = 0;
    chk_reset_vals("rst_sreq");
    rst = 1'b0;
    seq_check("rst_sreq_rel", 22, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
